// File: rtl/uart_tx.sv
// uart_tx: 8N1 asynchronous serial transmitter, LSB first, with a one-byte
// holding register so the host can queue the next character while the
// current one is being shifted out.
module uart_tx #(
    parameter int BAUDRATE = 104
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [7:0] data,
    output logic       ready,
    output logic       busy,
    output logic       tx
);

    localparam int CW = (BAUDRATE > 1) ? $clog2(BAUDRATE) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        TRANS = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [7:0]      hold_data;
    logic            hold_full;
    logic [9:0]      shift;
    logic [9:0]      frame_word;
    logic [CW-1:0]   baud_cnt;
    logic [3:0]      bit_cnt;

    logic            accept;
    logic            tick;
    logic            frame_done;
    logic            tx_next;
    logic            busy_next;

    assign accept     = start && !hold_full;
    assign ready      = ~hold_full;
    assign frame_word = {1'b1, hold_data, 1'b0};
    assign tick       = (state == TRANS) && (baud_cnt == CW'(BAUDRATE - 1));
    assign frame_done = tick && (bit_cnt == 4'd9);

    // State register; synchronous active-low reset returns the FSM to IDLE.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the values tx and busy take at the coming edge.
    always_comb begin
        state_next = IDLE;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
        case (state)
            IDLE: begin
                state_next = hold_full ? LOAD : IDLE;
            end
            LOAD: begin
                state_next = TRANS;
                tx_next    = frame_word[0];
                busy_next  = 1'b1;
            end
            TRANS: begin
                busy_next  = 1'b1;
                tx_next    = tick ? shift[0] : tx;
                state_next = TRANS;
                if (frame_done) begin
                    state_next = hold_full ? LOAD : IDLE;
                    busy_next  = hold_full;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Holding register, shift register, baud/bit counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            hold_data <= 8'h00;
            hold_full <= 1'b0;
            shift     <= 10'h3FF;
            baud_cnt  <= '0;
            bit_cnt   <= 4'd0;
            tx        <= 1'b1;
            busy      <= 1'b0;
        end else begin
            tx   <= tx_next;
            busy <= busy_next;

            if (accept) begin
                hold_data <= data;
                hold_full <= 1'b1;
            end else if (state == LOAD) begin
                hold_full <= 1'b0;
            end

            if (state == LOAD) begin
                shift    <= {1'b1, frame_word[9:1]};
                baud_cnt <= '0;
                bit_cnt  <= 4'd0;
            end else if (state == TRANS) begin
                if (tick) begin
                    baud_cnt <= '0;
                    bit_cnt  <= bit_cnt + 4'd1;
                    shift    <= {1'b1, shift[9:1]};
                end else begin
                    baud_cnt <= baud_cnt + 1'b1;
                end
            end else begin
                baud_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with a serial-line decoder feeding
// a byte scoreboard. Two instances: BAUDRATE=4 and the default 104.
module tb_uart_tx;

    logic       clk = 1'b0;
    int         cyc = 0;

    logic       rstn4 = 1'b0;
    logic       start4 = 1'b0;
    logic [7:0] data4 = 8'h00;
    logic       ready4;
    logic       busy4;
    logic       tx4;

    logic       rstn104 = 1'b0;
    logic       start104 = 1'b0;
    logic [7:0] data104 = 8'h00;
    logic       ready104;
    logic       busy104;
    logic       tx104;

    int         checks = 0;
    int         errors = 0;

    logic [7:0] q4[$];
    logic [7:0] q104[$];
    int         starts4[$];
    logic       mon_en[2] = '{1'b1, 1'b1};
    int         frames[2] = '{0, 0};

    uart_tx #(.BAUDRATE(4)) u4 (
        .clk   (clk),
        .rstn  (rstn4),
        .start (start4),
        .data  (data4),
        .ready (ready4),
        .busy  (busy4),
        .tx    (tx4)
    );

    uart_tx u104 (
        .clk   (clk),
        .rstn  (rstn104),
        .start (start104),
        .data  (data104),
        .ready (ready104),
        .busy  (busy104),
        .tx    (tx104)
    );

    // Free-running clock and edge counter.
    always #5 clk = ~clk;

    // Counts rising edges so timing expectations can be stated in cycles.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) step();
    endtask

    function automatic logic tx_of(input int sel);
        return (sel == 0) ? tx4 : tx104;
    endfunction

    // Line decoder: samples mid-bit, then pops the scoreboard and compares.
    task automatic monitor(input int sel, input int baud);
        logic [7:0] b;
        logic [7:0] expd;
        forever begin
            step();
            if (mon_en[sel] && tx_of(sel) === 1'b0) begin
                if (sel == 0) starts4.push_back(cyc);
                wait_cycles(baud / 2);
                check_output("rx_start_mid", 32'(tx_of(sel)), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    wait_cycles(baud);
                    b[i] = tx_of(sel);
                end
                wait_cycles(baud);
                check_output("rx_stop_bit", 32'(tx_of(sel)), 32'd1);
                frames[sel]++;
                if (sel == 0) begin
                    check_output("rx4_expected_present", 32'(q4.size() > 0), 32'd1);
                    if (q4.size() > 0) begin
                        expd = q4.pop_front();
                        check_output("rx4_byte", 32'(b), 32'(expd));
                    end
                end else begin
                    check_output("rx104_expected_present", 32'(q104.size() > 0), 32'd1);
                    if (q104.size() > 0) begin
                        expd = q104.pop_front();
                        check_output("rx104_byte", 32'(b), 32'(expd));
                    end
                end
            end
        end
    endtask

    initial monitor(0, 4);
    initial monitor(1, 104);

    // Hard time limit so the run always ends.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        int         k;
        int         e;
        int         e0;
        int         f0;
        logic [9:0] frame;
        logic       dropped;
        logic       quiet;

        // Reset, with start asserted to show reset wins.
        start4 = 1'b1;
        data4  = 8'hEE;
        wait_cycles(3);
        rstn4   = 1'b1;
        rstn104 = 1'b1;
        start4  = 1'b0;
        check_output("rst_tx4", 32'(tx4), 32'd1);
        check_output("rst_ready4", 32'(ready4), 32'd1);
        check_output("rst_busy4", 32'(busy4), 32'd0);
        check_output("rst_tx104", 32'(tx104), 32'd1);
        check_output("rst_ready104", 32'(ready104), 32'd1);
        check_output("rst_busy104", 32'(busy104), 32'd0);
        wait_cycles(3);
        check_output("rst_idle_busy4", 32'(busy4), 32'd0);

        // 0x55 from idle, cycle-exact waveform.
        data4 = 8'h55; start4 = 1'b1; q4.push_back(8'h55);
        step(); k = cyc; start4 = 1'b0;
        check_output("t1_ready_after_accept", 32'(ready4), 32'd0);
        step();
        check_output("t1_load_tx", 32'(tx4), 32'd1);
        check_output("t1_load_busy", 32'(busy4), 32'd0);
        frame = {1'b1, 8'h55, 1'b0};
        for (int n = 2; n < 42; n++) begin
            step();
            check_output("t1_tx_bit", 32'(tx4), 32'(frame[(n - 2) / 4]));
            check_output("t1_busy", 32'(busy4), 32'd1);
            check_output("t1_ready", 32'(ready4), 32'd1);
        end
        step();
        check_output("t1_busy_end", 32'(busy4), 32'd0);
        check_output("t1_tx_end", 32'(tx4), 32'd1);
        check_output("t1_end_cycle", 32'(cyc - k), 32'd42);
        wait_cycles(5);

        // Back-to-back 0xA5, 0x3C, plus an ignored 0xFF.
        f0 = frames[0];
        data4 = 8'hA5; start4 = 1'b1; q4.push_back(8'hA5);
        step(); k = cyc; start4 = 1'b0;
        step();
        step();
        check_output("t2_ready_free", 32'(ready4), 32'd1);
        data4 = 8'h3C; start4 = 1'b1; q4.push_back(8'h3C);
        step(); start4 = 1'b0;
        step();
        check_output("t2_ready_full", 32'(ready4), 32'd0);
        data4 = 8'hFF; start4 = 1'b1;
        step(); start4 = 1'b0;
        dropped = 1'b0;
        for (int n = 6; n <= 82; n++) begin
            step();
            if (busy4 !== 1'b1) dropped = 1'b1;
        end
        check_output("t2_busy_continuous", 32'(dropped), 32'd0);
        step();
        check_output("t2_busy_end", 32'(busy4), 32'd0);
        check_output("t2_frames", 32'(frames[0] - f0), 32'd2);
        check_output("t2_queue_empty", 32'(q4.size()), 32'd0);
        check_output("t2_start_count", 32'(starts4.size() >= 2), 32'd1);
        if (starts4.size() >= 2) begin
            check_output("t2_first_start", 32'(starts4[starts4.size() - 2]), 32'(k + 2));
            check_output("t2_second_start", 32'(starts4[starts4.size() - 1]), 32'(k + 43));
        end
        wait_cycles(3);

        // Reset in the middle of bit 3 of 0x00, with 0x77 queued.
        mon_en[0] = 1'b0;
        data4 = 8'h00; start4 = 1'b1;
        step(); k = cyc; start4 = 1'b0;
        step();
        step();
        data4 = 8'h77; start4 = 1'b1;
        step(); start4 = 1'b0;
        check_output("t3_ready_full", 32'(ready4), 32'd0);
        wait_cycles(11);
        check_output("t3_tx_bit3", 32'(tx4), 32'd0);
        check_output("t3_busy_mid", 32'(busy4), 32'd1);
        rstn4 = 1'b0;
        step();
        check_output("t3_rst_tx", 32'(tx4), 32'd1);
        check_output("t3_rst_busy", 32'(busy4), 32'd0);
        check_output("t3_rst_ready", 32'(ready4), 32'd1);
        rstn4 = 1'b1;
        quiet = 1'b1;
        for (int n = 0; n < 60; n++) begin
            step();
            if (tx4 !== 1'b1 || busy4 !== 1'b0) quiet = 1'b0;
        end
        check_output("t3_quiet_after_reset", 32'(quiet), 32'd1);
        mon_en[0] = 1'b1;

        // Default baud: 0x41, every cycle of the 1040-cycle frame.
        data104 = 8'h41; start104 = 1'b1; q104.push_back(8'h41);
        step(); k = cyc; start104 = 1'b0;
        step();
        frame = {1'b1, 8'h41, 1'b0};
        for (int n = 2; n < 1042; n++) begin
            step();
            check_output("t4_tx_bit", 32'(tx104), 32'(frame[(n - 2) / 104]));
        end
        check_output("t4_busy_last", 32'(busy104), 32'd1);
        step();
        check_output("t4_busy_end", 32'(busy104), 32'd0);
        check_output("t4_frames", 32'(frames[1]), 32'd1);
        wait_cycles(5);

        // start held high with data changing every cycle.
        f0 = frames[0];
        e0 = cyc + 1;
        for (int n = 0; n < 130; n++) begin
            e = cyc + 1;
            data4  = 8'((e * 29 + 7) & 255);
            start4 = (e <= e0 + 85);
            if (e == e0 || e == e0 + 3 || e == e0 + 44 || e == e0 + 85)
                q4.push_back(data4);
            step();
        end
        start4 = 1'b0;
        for (int t = 0; t < 300 && q4.size() != 0; t++) step();
        check_output("t5_queue_drained", 32'(q4.size()), 32'd0);
        wait_cycles(10);
        check_output("t5_frames", 32'(frames[0] - f0), 32'd4);
        check_output("t5_busy_end", 32'(busy4), 32'd0);
        check_output("t5_ready_end", 32'(ready4), 32'd1);
        check_output("final_q104_empty", 32'(q104.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Asynchronous serial transmitter. It is the transmit counterpart of the board's UART receiver: same frame format (8N1, LSB first), same baud parameterisation, same system clock (12 MHz on the ICEstick). It provides a one-byte holding register, so the host can queue the next character while the current one is being shifted out. This allows back-to-back frames with a fixed gap.

## Interface
- BAUDRATE, default `B115200 (104 = clock cycles per bit at 12 MHz) — bit period in clk cycles; legal range 2..65535
- clk  in  1  system clock
- rstn  in  1  reset, synchronous, active-low
- start  in  1  write strobe; byte accepted on a rising clk edge where start=1 and ready=1
- data  in  8  byte to send; sampled only on the accepting edge
- ready  out  1  holding register empty (1 = a write will be accepted)
- busy  out  1  frame in progress on tx
- tx  out  1  serial line, registered, idles high

## Operation
- Frame: start bit 0, data[0]..data[7], stop bit 1. That is 10 bits, each exactly BAUDRATE cycles.
- Holding register (hold_data, hold_full):
  - Set on an accepting edge.
  - Cleared when the FSM copies it into the shift register.
  - ready = ~hold_full.
  - start while ready=0 is ignored: no state change, byte dropped.
- Shift register: 10 bits, loaded with {1, hold_data, 0}. On each baud tick, tx takes bit 0 and the register shifts right, filling with 1.
- Baud counter:
  - Counts 0..BAUDRATE-1 while in TRANS.
  - Tick when count = BAUDRATE-1, then wraps to 0.
  - Held at 0 outside TRANS.
  - Width = clog2(BAUDRATE).
- Bit counter: 0..10, cleared in LOAD, incremented on each tick.
- FSM states: IDLE, LOAD, TRANS.
  - IDLE: tx=1, busy=0. If hold_full, go to LOAD.
  - LOAD (1 cycle): copy the holding register into the shift register, clear hold_full, clear counters, busy=1, tx stays 1. Go to TRANS.
  - TRANS: busy=1, tx driven from the shift register. When the 10th tick occurs (bit counter reaches 10), go to LOAD if hold_full, else to IDLE.
  - Any unused encoding goes to IDLE.
- Simultaneous events:
  - An accepting write in the same cycle as LOAD frees the holding register and sets hold_full again; the new byte is kept.
  - A write during the final stop-bit cycle is seen by the TRANS exit decision only if hold_full was already 1 at that edge. Otherwise the FSM goes to IDLE and reaches LOAD next cycle.

## Timing
- Reset values: tx=1, ready=1, busy=0. FSM in IDLE, hold_full=0, counters 0.
- Reset has priority over start.
- Reset mid-frame: tx=1 and ready=1 at the edge after rstn is sampled low. The partial frame is abandoned and the holding register is discarded.
- Latency, with the accepting edge at cycle k:
  - LOAD at k+1.
  - tx falls (start bit) at edge k+2.
  - ready returns to 1 at k+2, since the holding register is freed in LOAD.
- Bit n (n=0 for the start bit) occupies edges k+2+n·BAUDRATE through k+2+(n+1)·BAUDRATE−1.
- The stop bit ends at k+2+10·BAUDRATE. Then busy=0 if nothing is queued.
- Back-to-back: the next start bit begins 10·BAUDRATE+1 cycles after the previous start bit. The stop bit is stretched by the 1-cycle LOAD.
- busy rises at k+2 and stays 1 continuously across back-to-back frames.

## Test plan
- BAUDRATE=4, send 0x55 from idle. Required: tx low at k+2 for 4 cycles, then 1,0,1,0,1,0,1,0 (LSB first, 4 cycles each), then stop high. busy=0 at k+42, ready=1 from k+2.
- BAUDRATE=4, write 0xA5, then write 0x3C as soon as ready=1. Required: second start bit 41 cycles after the first; decoded bytes 0xA5 and 0x3C; busy never drops between frames.
- Writes while ready=0 (third byte 0xFF pulsed during the 0x3C queue). Required: 0xFF never appears on tx, and only two frames are sent.
- Reset asserted mid-frame (bit 3 of 0x00). Required: tx=1, busy=0, ready=1 on the next edge; no further transitions on tx until a new write.
- Default BAUDRATE=104, send 0x41 (a reference UART model receives at 115200 from a 12 MHz clock). Required: each bit is exactly 104 cycles, frame is 1040 cycles, and the model decodes 0x41.
- start held high continuously with data changing every cycle (BAUDRATE=4). Required: exactly the bytes present on the accepting edges (ready=1) are transmitted, in order, with no loss and no duplication.
